aemb_fetch_pf: RTL and testbench
================================

// Module: aemb_fetch_pf
// PURPOSE
//  Parametrised instruction-fetch unit with a prefetch queue for the AEMB core.
//  - Issues Wishbone classic reads (stb/ack) ahead of execution.
//  - Buffers returned words, tagged with their addresses, in a DEPTH-entry FIFO.
//  - Presents the FIFO head to decode as rINST/rPC/rVLD.
//  - Redirects on branch, HWINT, HWEXC and SWEXC (all three vectors implemented).
// PARAMETERS
//  ISIZ     32         instruction address width; iwb_adr_o[1:0] always 0
//  DEPTH    4          prefetch FIFO entries; power of 2, >= 2
//  RST_VEC  32'h0      fetch address after reset
//  HWINT_V  32'h10     vector for rFSM=01
//  HWEXC_V  32'h20     vector for rFSM=10
//  SWEXC_V  32'h08     vector for rFSM=11
// PORTS
//  nclk       in   1     clock; all flops update on its falling edge
//  nrst       in   1     asynchronous reset, active-high
//  iwb_adr_o  out  ISIZ  word-aligned fetch address
//  iwb_stb_o  out  1     read request; held with stable address until ack
//  iwb_ack_i  in   1     read acknowledge; ignored while iwb_stb_o=0
//  iwb_dat_i  in   32    read data, valid with ack
//  frun       in   1     pipeline advance; qualifies pop and redirect
//  rFSM       in   2     00 normal, 01 HWINT, 10 HWEXC, 11 SWEXC
//  rBRA       in   1     branch taken; target on rRESULT (only when rFSM=00)
//  rRESULT    in   32    branch target
//  rINST      out  32    instruction at FIFO head
//  rPC        out  32    address of rINST, bits[1:0]=0
//  rPCNXT     out  32    rPC+4, mod 2^32
//  rVLD       out  1     FIFO non-empty; rINST/rPC meaningful
// BEHAVIOUR
//  - Reset (async): FIFO empty, rVLD=0, rINST=0, rPC=0, iwb_stb_o=0, fetch ptr=RST_VEC, drop=0.
//  - Issue: stb rises at the first falling edge after reset release.
//    - Next stb is allowed only while (FIFO level + outstanding) < DEPTH.
//    - At most one outstanding request.
//  - Accept: an ack with drop=0 pushes {adr,dat} into the FIFO.
//    - The fetch ptr advances by 4 (wraps 0xFFFFFFFC -> 0).
//    - stb stays high back-to-back if space remains; otherwise it falls on that edge.
//  - Pop: at an edge with frun=1, rVLD=1 and no redirect, the head is removed.
//    - rINST/rPC show the next entry combinationally from FIFO registers.
//  - Push and pop in the same edge: level unchanged. Full FIFO with pop: stb may reassert on that edge.
//  - Redirect: fires at an edge with frun=1 and (rFSM!=00 or rBRA=1).
//    - Priority: rFSM vector over rBRA. Target = vector or {rRESULT[31:2],2'b00}.
//    - FIFO is flushed and the fetch ptr takes the target.
//    - Head is not popped that edge; rVLD=0 on the following cycle.
//  - Redirect with a transaction outstanding (stb=1, no ack that edge):
//    - Wishbone classic cannot abort, so stb/adr are held and drop=1.
//    - The returning ack is discarded, drop clears, and the next request uses the target.
//  - Redirect coinciding with ack: the acked word is discarded.
//    - The next request starts at the target, on the following edge at earliest.
//  - A second redirect while drop=1 only updates the target; one word is still discarded.
//  - frun=0: no pop, no redirect; fetching continues until the FIFO is full.
//  - Latency: redirect edge N, ack at edge N+1, rVLD=1 after edge N+1.
//    - Min branch penalty 2 cycles (3 if a transaction is pending).
//  - Width: address arithmetic is ISIZ bits. rPC and rPCNXT are zero-extended to 32.
// TESTING
//  1. Reset release with ack tied 1 -> iwb_adr_o 0x0,0x4,0x8,... and rPC follows.
//     - rVLD=1 one cycle after the first ack.
//  2. frun=0, ack=1, DEPTH=4 -> exactly 4 acks; stb low with level=4.
//     - Then frun=1 for one cycle -> one pop and stb reasserts at adr 0x10.
//  3. Branch rBRA=1, rRESULT=0x103 while stb pending without ack.
//     - Held adr is acked and the data dropped.
//     - Next adr=0x100, first rPC=0x100, no stale rVLD.
//  4. rFSM=01/10/11 each with rBRA=1, rRESULT=0x400 -> fetch at 0x10/0x20/0x08; rBRA ignored.
//  5. RST_VEC=0xFFFFFFF8 -> adr 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
//     - rPCNXT at rPC=0xFFFFFFFC is 0x0.
//  6. Assert nrst with stb high and FIFO half-full -> outputs reset immediately.
//     - Restart from RST_VEC and the pre-reset ack is ignored.

Source files
------------

// File: rtl/aemb_fetch_pf_if.sv
// Wishbone classic instruction-read port of the AEMB prefetch unit.
// The fetch unit is the master; memory (or the bench) is the slave.
interface aemb_fetch_pf_if #(
  parameter int ISIZ = 32
);
  logic [ISIZ-1:0] iwb_adr_o;
  logic            iwb_stb_o;
  logic            iwb_ack_i;
  logic [31:0]     iwb_dat_i;

  modport master (output iwb_adr_o, output iwb_stb_o, input iwb_ack_i, input iwb_dat_i);
  modport slave  (input iwb_adr_o, input iwb_stb_o, output iwb_ack_i, output iwb_dat_i);
endinterface

// File: rtl/aemb_fetch_pf.sv
// AEMB instruction fetch with a DEPTH-entry prefetch FIFO of {address, word} pairs.
// All state updates on the falling edge of nclk; nrst is an asynchronous active-high reset.
module aemb_fetch_pf #(
  parameter int          ISIZ    = 32,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] RST_VEC = 32'h0000_0000,
  parameter logic [31:0] HWINT_V = 32'h0000_0010,
  parameter logic [31:0] HWEXC_V = 32'h0000_0020,
  parameter logic [31:0] SWEXC_V = 32'h0000_0008
) (
  input  logic                   nclk,
  input  logic                   nrst,
  aemb_fetch_pf_if.master        iwb,
  input  logic                   frun,
  input  logic [1:0]             rFSM,
  input  logic                   rBRA,
  input  logic [31:0]            rRESULT,
  output logic [31:0]            rINST,
  output logic [31:0]            rPC,
  output logic [31:0]            rPCNXT,
  output logic                   rVLD
);

  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              LW    = AW + 1;
  localparam logic [LW-1:0]   FULL  = LW'(DEPTH);
  localparam logic [ISIZ-1:0] RST_A = {RST_VEC[ISIZ-1:2], 2'b00};

  logic [ISIZ-1:0] adr_q, adr_d;
  logic [ISIZ-1:0] ptr_q, ptr_d;
  logic            stb_q, stb_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [LW-1:0]   lvl_q, lvl_d;

  logic [ISIZ-1:0] fifo_adr_q [DEPTH];
  logic [ISIZ-1:0] fifo_adr_d [DEPTH];
  logic [31:0]     fifo_dat_q [DEPTH];
  logic [31:0]     fifo_dat_d [DEPTH];
  logic [DEPTH-1:0] wen;

  logic            vld, ack_ok, redir, pop, push, hold;
  logic [31:0]     tgt32;
  logic [ISIZ-1:0] tgt;
  logic [31:0]     pc_ext;

  assign vld = (lvl_q != '0);

  always_comb begin
    ack_ok = stb_q & iwb.iwb_ack_i;
    redir  = frun & ((rFSM != 2'b00) | rBRA);
    pop    = frun & vld & ~redir;
    // A redirect on the ack edge, or a pending drop, discards the returning word.
    push   = ack_ok & ~drop_q & ~redir;
    hold   = stb_q & ~iwb.iwb_ack_i;

    unique case (rFSM)
      2'b01:   tgt32 = HWINT_V;
      2'b10:   tgt32 = HWEXC_V;
      2'b11:   tgt32 = SWEXC_V;
      default: tgt32 = {rRESULT[31:2], 2'b00};
    endcase
    tgt = {tgt32[ISIZ-1:2], 2'b00};

    ptr_d = ptr_q;
    if (redir)     ptr_d = tgt;
    else if (push) ptr_d = ptr_q + ISIZ'(4);

    rd_d  = rd_q;
    wr_d  = wr_q;
    lvl_d = lvl_q;
    if (redir) begin
      rd_d  = '0;
      wr_d  = '0;
      lvl_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      lvl_d = lvl_q + LW'(1);
      else if (pop && !push) lvl_d = lvl_q - LW'(1);
    end

    // Only one transaction in flight, so with none held the level alone gates issue.
    stb_d = hold | (lvl_d != FULL);
    adr_d = adr_q;
    if (!hold && stb_d) adr_d = ptr_d;

    drop_d = drop_q;
    if (redir && hold) drop_d = 1'b1;
    else if (ack_ok)   drop_d = 1'b0;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign wen[gi]        = push & (wr_q == AW'(gi));
    assign fifo_adr_d[gi] = wen[gi] ? adr_q : fifo_adr_q[gi];
    assign fifo_dat_d[gi] = wen[gi] ? iwb.iwb_dat_i : fifo_dat_q[gi];
  end

  always_ff @(negedge nclk or posedge nrst) begin
    if (nrst) begin
      adr_q  <= RST_A;
      ptr_q  <= RST_A;
      stb_q  <= 1'b0;
      drop_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      lvl_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_adr_q[i] <= '0;
        fifo_dat_q[i] <= '0;
      end
    end else begin
      adr_q      <= adr_d;
      ptr_q      <= ptr_d;
      stb_q      <= stb_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      lvl_q      <= lvl_d;
      fifo_adr_q <= fifo_adr_d;
      fifo_dat_q <= fifo_dat_d;
    end
  end

  always_comb begin
    pc_ext            = '0;
    pc_ext[ISIZ-1:0]  = vld ? fifo_adr_q[rd_q] : '0;
    rPC               = pc_ext;
    rPCNXT            = pc_ext + 32'd4;
    rINST             = vld ? fifo_dat_q[rd_q] : 32'h0;
    rVLD              = vld;
  end

  assign iwb.iwb_adr_o = adr_q;
  assign iwb.iwb_stb_o = stb_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, rRESULT[1:0], tgt32};

endmodule

// File: tb/tb_aemb_fetch_pf.sv
// Bench for aemb_fetch_pf: cycle vector table for fill/drain, scoreboarded sequences
// for redirects, drops, vectors, wrap-around and asynchronous reset.
module tb_aemb_fetch_pf;

  logic nclk = 1'b0;
  always #5 nclk = ~nclk;

  logic        nrst, rst2;
  logic        ack1, ack2, frun1, frun2, bra1;
  logic [1:0]  fsm1;
  logic [31:0] res1;
  logic [31:0] inst1, pc1, pcn1, inst2, pc2, pcn2;
  logic        vld1, vld2;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;
  logic [31:0] adrq [$];
  logic [31:0] pcq  [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a3c_0000;
  endfunction

  aemb_fetch_pf_if #(.ISIZ(32)) bus1 ();
  aemb_fetch_pf_if #(.ISIZ(32)) bus2 ();
  assign bus1.iwb_ack_i = ack1;
  assign bus1.iwb_dat_i = memf(bus1.iwb_adr_o);
  assign bus2.iwb_ack_i = ack2;
  assign bus2.iwb_dat_i = memf(bus2.iwb_adr_o);

  aemb_fetch_pf #(.ISIZ(32), .DEPTH(4), .RST_VEC(32'h0000_0000)) u_dut (
    .nclk(nclk), .nrst(nrst), .iwb(bus1), .frun(frun1), .rFSM(fsm1), .rBRA(bra1),
    .rRESULT(res1), .rINST(inst1), .rPC(pc1), .rPCNXT(pcn1), .rVLD(vld1));

  aemb_fetch_pf #(.ISIZ(32), .DEPTH(4), .RST_VEC(32'hFFFF_FFF8)) u_dut2 (
    .nclk(nclk), .nrst(rst2), .iwb(bus2), .frun(frun2), .rFSM(2'b00), .rBRA(1'b0),
    .rRESULT(32'h0), .rINST(inst2), .rPC(pc2), .rPCNXT(pcn2), .rVLD(vld2));

  typedef struct {
    logic        rst;
    logic        ack;
    logic        frun;
    logic        e_stb;
    logic [31:0] e_adr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one edge's inputs, score the handshake and pop that edge will perform, then advance.
  task automatic tick(input logic a, input logic f, input logic [1:0] m, input logic b,
                      input logic [31:0] r);
    logic [31:0] e;
    ack1 = a; frun1 = f; fsm1 = m; bra1 = b; res1 = r;
    #1;
    if (bus1.iwb_stb_o && a && !nrst) begin
      $display("txn adr=%h dat=%h", bus1.iwb_adr_o, bus1.iwb_dat_i);
      if (sb_en && adrq.size() > 0) begin
        e = adrq.pop_front();
        chk("req_adr", bus1.iwb_adr_o, e);
      end
    end
    if (sb_en && f && vld1 && m == 2'b00 && !b && pcq.size() > 0) begin
      e = pcq.pop_front();
      chk("pop_pc", pc1, e);
      chk("pop_inst", inst1, memf(e));
    end
    @(negedge nclk);
    @(posedge nclk);
    #1;
  endtask

  task automatic rst_pulse();
    nrst = 1'b1;
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    nrst = 1'b0;
    adrq.delete();
    pcq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] vec;
    nrst = 1'b1; rst2 = 1'b1;
    ack1 = 1'b0; frun1 = 1'b0; fsm1 = 2'b00; bra1 = 1'b0; res1 = 32'h0;
    ack2 = 1'b0; frun2 = 1'b0;

    // rst ack frun | stb adr vld pc  (after the edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h4};

    @(posedge nclk);
    #1;
    for (int i = 0; i < 15; i++) begin
      nrst = tbl[i].rst;
      tick(tbl[i].ack, tbl[i].frun, 2'b00, 1'b0, 32'h0);
      chk($sformatf("t%0d_stb", i), 32'(bus1.iwb_stb_o), 32'(tbl[i].e_stb));
      chk($sformatf("t%0d_adr", i), bus1.iwb_adr_o, tbl[i].e_adr);
      chk($sformatf("t%0d_vld", i), 32'(vld1), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d_pc", i), pc1, tbl[i].e_pc);
      if (tbl[i].e_vld) begin
        chk($sformatf("t%0d_inst", i), inst1, memf(tbl[i].e_pc));
        chk($sformatf("t%0d_pcnxt", i), pcn1, tbl[i].e_pc + 32'd4);
      end else if (tbl[i].rst) begin
        chk($sformatf("t%0d_inst_rst", i), inst1, 32'h0);
      end
    end

    sb_en = 1'b1;

    // Branch while a request is held without ack: held word dropped, refetch at 0x100.
    rst_pulse();
    adrq.push_back(32'h000); adrq.push_back(32'h100); adrq.push_back(32'h104);
    pcq.push_back(32'h100);  pcq.push_back(32'h104);
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s3_adr0", bus1.iwb_adr_o, 32'h0);
    tick(1'b0, 1'b1, 2'b00, 1'b1, 32'h103);
    chk("s3_hold_stb", 32'(bus1.iwb_stb_o), 32'd1);
    chk("s3_hold_adr", bus1.iwb_adr_o, 32'h0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s3_no_stale", 32'(vld1), 32'd0);
    chk("s3_tgt_adr", bus1.iwb_adr_o, 32'h100);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s3_vld", 32'(vld1), 32'd1);
    chk("s3_pc", pc1, 32'h100);
    tick(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
    chk("s3_drained", 32'(vld1), 32'd0);
    chk("s3_adrq_left", adrq.size(), 32'd0);
    chk("s3_pcq_left", pcq.size(), 32'd0);

    // Second redirect during a drop only retargets; exactly one word is discarded.
    rst_pulse();
    adrq.push_back(32'h000); adrq.push_back(32'h010);
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 2'b00, 1'b1, 32'h200);
    tick(1'b0, 1'b1, 2'b01, 1'b0, 32'h0);
    chk("s3b_hold_adr", bus1.iwb_adr_o, 32'h0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s3b_no_stale", 32'(vld1), 32'd0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s3b_pc", pc1, 32'h10);
    chk("s3b_adrq_left", adrq.size(), 32'd0);

    // Exception/interrupt vectors take priority over rBRA; redirect lands on an ack edge.
    for (int m = 1; m <= 3; m++) begin
      vec = (m == 1) ? 32'h10 : (m == 2) ? 32'h20 : 32'h08;
      rst_pulse();
      adrq.push_back(32'h0); adrq.push_back(vec);
      tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 2'(m), 1'b1, 32'h400);
      chk($sformatf("s4_%0d_adr", m), bus1.iwb_adr_o, vec);
      chk($sformatf("s4_%0d_flush", m), 32'(vld1), 32'd0);
      tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
      chk($sformatf("s4_%0d_vld", m), 32'(vld1), 32'd1);
      chk($sformatf("s4_%0d_pc", m), pc1, vec);
      chk($sformatf("s4_%0d_pcnxt", m), pcn1, vec + 32'd4);
      chk($sformatf("s4_%0d_inst", m), inst1, memf(vec));
      chk($sformatf("s4_%0d_adrq_left", m), adrq.size(), 32'd0);
    end

    // Asynchronous reset with a request pending and the FIFO half full.
    rst_pulse();
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s6_pre_adr", bus1.iwb_adr_o, 32'h8);
    chk("s6_pre_vld", 32'(vld1), 32'd1);
    nrst = 1'b1;
    #1;
    chk("s6_rst_stb", 32'(bus1.iwb_stb_o), 32'd0);
    chk("s6_rst_vld", 32'(vld1), 32'd0);
    chk("s6_rst_pc", pc1, 32'h0);
    chk("s6_rst_inst", inst1, 32'h0);
    chk("s6_rst_adr", bus1.iwb_adr_o, 32'h0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    nrst = 1'b0;
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s6_rel_stb", 32'(bus1.iwb_stb_o), 32'd1);
    chk("s6_rel_adr", bus1.iwb_adr_o, 32'h0);
    chk("s6_rel_vld", 32'(vld1), 32'd0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s6_first_pc", pc1, 32'h0);
    chk("s6_first_vld", 32'(vld1), 32'd1);

    // Address wrap on the second instance reset to 0xFFFFFFF8.
    rst2 = 1'b0; ack2 = 1'b1; frun2 = 1'b0;
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s5_adr0", bus2.iwb_adr_o, 32'hFFFF_FFF8);
    chk("s5_stb0", 32'(bus2.iwb_stb_o), 32'd1);
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s5_adr1", bus2.iwb_adr_o, 32'hFFFF_FFFC);
    chk("s5_pc1", pc2, 32'hFFFF_FFF8);
    chk("s5_pcnxt1", pcn2, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s5_adr2", bus2.iwb_adr_o, 32'h0);
    frun2 = 1'b1;
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("s5_pc2", pc2, 32'hFFFF_FFFC);
    chk("s5_pcnxt2", pcn2, 32'h0);
    chk("s5_inst2", inst2, memf(32'hFFFF_FFFC));
    chk("s5_vld2", 32'(vld2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
